usb_rx_data_fifo: RTL and testbench



---
 rtl/usb_rx_data_fifo.sv | 143 ++++++++++++++
 tb/tb_usb_rx_data_fifo.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_data_fifo.sv
// usb_rx_data_fifo
// Byte FIFO between the USB receiver and the bus-side slave. Bytes are pushed
// one per cycle by the receiver and drained in 1-, 2- or 4-byte reads.
//
// Ports:
//   clk, n_rst         clock, asynchronous active-low reset
//   clear              synchronous flush of pointers, occupancy, flags, rx_out
//   store_rx_data      push rx_data this cycle (dropped when full)
//   rx_data            byte to push
//   get_rx_data        read request
//   get_size           00 = 1 byte, 01 = 2 bytes, 1x = 4 bytes
//   rx_out             registered read data, oldest byte in [7:0]
//   rx_out_valid       one-cycle pulse after an accepted read
//   buffer_occupancy   bytes currently stored, 0..DEPTH
//   empty, full        decoded from the registered occupancy
//   overflow           sticky: a store was dropped
//   underflow          sticky: a read was refused
module usb_rx_data_fifo #(
   parameter int unsigned DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     n_rst,
   input  logic                     clear,
   input  logic                     store_rx_data,
   input  logic [7:0]               rx_data,
   input  logic                     get_rx_data,
   input  logic [1:0]               get_size,
   output logic [31:0]              rx_out,
   output logic                     rx_out_valid,
   output logic [$clog2(DEPTH):0]   buffer_occupancy,
   output logic                     empty,
   output logic                     full,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned OW = AW + 1;

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wp_q, wp_d;
   logic [AW-1:0] rp_q, rp_d;
   logic [OW-1:0] occ_q, occ_d;
   logic [31:0]   rx_out_q, rx_out_d;
   logic          valid_q, valid_d;
   logic          ovf_q, ovf_d;
   logic          unf_q, unf_d;

   logic [OW-1:0] rd_n;
   logic          wr_ok;
   logic          rd_ok;
   logic [31:0]   rd_word;

   always_comb begin
      unique case (get_size)
         2'b00:   rd_n = OW'(1);
         2'b01:   rd_n = OW'(2);
         default: rd_n = OW'(4);
      endcase
   end

   // All accept/refuse decisions use the pre-edge occupancy.
   assign wr_ok = store_rx_data && (occ_q != OW'(DEPTH));
   assign rd_ok = get_rx_data && (occ_q >= rd_n);

   // Bytes beyond the requested size read as zero.
   always_comb begin
      rd_word = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         if (OW'(i) < rd_n) begin
            rd_word[8*i +: 8] = mem_q[rp_q + AW'(i)];
         end
      end
   end

   always_comb begin
      wp_d     = wp_q;
      rp_d     = rp_q;
      occ_d    = occ_q;
      rx_out_d = rx_out_q;
      valid_d  = 1'b0;
      ovf_d    = ovf_q;
      unf_d    = unf_q;
      if (clear) begin
         wp_d     = '0;
         rp_d     = '0;
         occ_d    = '0;
         rx_out_d = '0;
         ovf_d    = 1'b0;
         unf_d    = 1'b0;
      end else begin
         if (wr_ok) begin
            wp_d = wp_q + AW'(1);
         end else if (store_rx_data) begin
            ovf_d = 1'b1;
         end
         if (rd_ok) begin
            rp_d     = rp_q + AW'(rd_n);
            rx_out_d = rd_word;
            valid_d  = 1'b1;
         end else if (get_rx_data) begin
            unf_d = 1'b1;
         end
         occ_d = occ_q + (wr_ok ? OW'(1) : OW'(0)) - (rd_ok ? rd_n : OW'(0));
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wp_q     <= '0;
         rp_q     <= '0;
         occ_q    <= '0;
         rx_out_q <= '0;
         valid_q  <= 1'b0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         wp_q     <= wp_d;
         rp_q     <= rp_d;
         occ_q    <= occ_d;
         rx_out_q <= rx_out_d;
         valid_q  <= valid_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   // Storage is not reset; occupancy gates every read so stale bytes never escape.
   always_ff @(posedge clk) begin
      if (!clear && wr_ok) begin
         mem_q[wp_q] <= rx_data;
      end
   end

   assign rx_out           = rx_out_q;
   assign rx_out_valid     = valid_q;
   assign buffer_occupancy = occ_q;
   assign empty            = (occ_q == '0);
   assign full             = (occ_q == OW'(DEPTH));
   assign overflow         = ovf_q;
   assign underflow        = unf_q;

endmodule

// File: tb/tb_usb_rx_data_fifo.sv
// Self-checking bench for usb_rx_data_fifo: a byte-queue model predicts each
// read word into a scoreboard that is drained as rx_out_valid pulses appear.
module tb_usb_rx_data_fifo;

   localparam int unsigned DEPTH = 64;

   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic        clear = 1'b0;
   logic        store_rx_data = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        get_rx_data = 1'b0;
   logic [1:0]  get_size = 2'b00;
   logic [31:0] rx_out;
   logic        rx_out_valid;
   logic [6:0]  buffer_occupancy;
   logic        empty;
   logic        full;
   logic        overflow;
   logic        underflow;

   usb_rx_data_fifo #(.DEPTH(DEPTH)) dut (
      .clk              (clk),
      .n_rst            (n_rst),
      .clear            (clear),
      .store_rx_data    (store_rx_data),
      .rx_data          (rx_data),
      .get_rx_data      (get_rx_data),
      .get_size         (get_size),
      .rx_out           (rx_out),
      .rx_out_valid     (rx_out_valid),
      .buffer_occupancy (buffer_occupancy),
      .empty            (empty),
      .full             (full),
      .overflow         (overflow),
      .underflow        (underflow)
   );

   always #5 clk = ~clk;

   int          tests = 0;
   int          failed = 0;

   logic [7:0]  mq[$];
   logic [31:0] exp_q[$];
   logic        m_ovf = 1'b0;
   logic        m_unf = 1'b0;
   logic        m_valid = 1'b0;
   logic [31:0] m_out = 32'h0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      exp_q.delete();
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
      m_valid = 1'b0;
      m_out   = 32'h0;
   endtask

   task automatic check_state(input string tag);
      chk({tag, ".valid"}, {31'h0, rx_out_valid}, {31'h0, m_valid});
      if (rx_out_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk({tag, ".unexpected_read"}, rx_out, 32'hxxxx_xxxx);
         end else begin
            m_out = exp_q.pop_front();
            chk({tag, ".rx_out"}, rx_out, m_out);
         end
      end else begin
         chk({tag, ".rx_out_hold"}, rx_out, m_out);
      end
      chk({tag, ".occ"}, {25'h0, buffer_occupancy}, mq.size());
      chk({tag, ".empty"}, {31'h0, empty}, {31'h0, mq.size() == 0});
      chk({tag, ".full"}, {31'h0, full}, {31'h0, mq.size() == DEPTH});
      chk({tag, ".overflow"}, {31'h0, overflow}, {31'h0, m_ovf});
      chk({tag, ".underflow"}, {31'h0, underflow}, {31'h0, m_unf});
   endtask

   // One clock cycle: drive at negedge, update model from pre-edge state,
   // then sample 1 time unit after the rising edge.
   task automatic step(input string tag, input logic st, input logic [7:0] d,
                       input logic gt, input logic [1:0] sz, input logic clr);
      int n;
      int occ;
      logic wr_ok, rd_ok;
      logic [31:0] w;
      @(negedge clk);
      store_rx_data = st;
      rx_data       = d;
      get_rx_data   = gt;
      get_size      = sz;
      clear         = clr;
      n   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      occ = mq.size();
      if (clr) begin
         model_reset();
      end else begin
         wr_ok = st && (occ < DEPTH);
         rd_ok = gt && (occ >= n);
         if (st && !wr_ok) m_ovf = 1'b1;
         if (gt && !rd_ok) m_unf = 1'b1;
         m_valid = rd_ok;
         if (rd_ok) begin
            w = 32'h0;
            for (int k = 0; k < n; k++) w[8*k +: 8] = mq[k];
            for (int k = 0; k < n; k++) void'(mq.pop_front());
            exp_q.push_back(w);
         end
         if (wr_ok) mq.push_back(d);
      end
      @(posedge clk);
      #1;
      check_state(tag);
      store_rx_data = 1'b0;
      get_rx_data   = 1'b0;
      clear         = 1'b0;
   endtask

   initial begin
      // Reset
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_rst = 1'b1;
      model_reset();
      step("reset_idle", 1'b0, 8'h00, 1'b0, 2'b00, 1'b0);
      chk("reset_rx_out", rx_out, 32'h0);

      // Four stores then a 4-byte read
      step("st11", 1'b1, 8'h11, 1'b0, 2'b00, 1'b0);
      step("st22", 1'b1, 8'h22, 1'b0, 2'b00, 1'b0);
      step("st33", 1'b1, 8'h33, 1'b0, 2'b00, 1'b0);
      step("st44", 1'b1, 8'h44, 1'b0, 2'b00, 1'b0);
      step("rd4", 1'b0, 8'h00, 1'b1, 2'b10, 1'b0);
      chk("rd4_word", rx_out, 32'h4433_2211);
      step("rd4_after", 1'b0, 8'h00, 1'b0, 2'b00, 1'b0);

      // Underflow then a 1-byte read
      step("stA5", 1'b1, 8'hA5, 1'b0, 2'b00, 1'b0);
      step("rd4_unf", 1'b0, 8'h00, 1'b1, 2'b11, 1'b0);
      chk("unf_flag", {31'h0, underflow}, 32'h1);
      step("rd1", 1'b0, 8'h00, 1'b1, 2'b00, 1'b0);
      chk("rd1_word", rx_out, 32'h0000_00A5);

      // Fill, overflow, drain
      for (int i = 0; i < 64; i++) step("fill", 1'b1, 8'(i), 1'b0, 2'b00, 1'b0);
      chk("full_flag", {31'h0, full}, 32'h1);
      step("st_ovf", 1'b1, 8'hFF, 1'b0, 2'b00, 1'b0);
      chk("ovf_occ", {25'h0, buffer_occupancy}, 32'd64);
      for (int i = 0; i < 16; i++) step("drain", 1'b0, 8'h00, 1'b1, 2'b10, 1'b0);
      chk("drain_last", rx_out, 32'h3F3E_3D3C);

      // Pointer wrap
      for (int i = 0; i < 60; i++) step("w60", 1'b1, 8'(i + 8'h40), 1'b0, 2'b00, 1'b0);
      for (int i = 0; i < 15; i++) step("r60", 1'b0, 8'h00, 1'b1, 2'b10, 1'b0);
      for (int i = 0; i < 8; i++) step("w8", 1'b1, 8'(8'h80 + i), 1'b0, 2'b00, 1'b0);
      step("wrap_rd0", 1'b0, 8'h00, 1'b1, 2'b10, 1'b0);
      chk("wrap_word0", rx_out, 32'h8382_8180);
      step("wrap_rd1", 1'b0, 8'h00, 1'b1, 2'b10, 1'b0);
      chk("wrap_word1", rx_out, 32'h8786_8584);

      // Same-cycle store and 2-byte read
      step("st01", 1'b1, 8'h01, 1'b0, 2'b00, 1'b0);
      step("st02", 1'b1, 8'h02, 1'b0, 2'b00, 1'b0);
      step("st_rd2", 1'b1, 8'h99, 1'b1, 2'b01, 1'b0);
      chk("st_rd2_word", rx_out, 32'h0000_0201);
      chk("st_rd2_occ", {25'h0, buffer_occupancy}, 32'd1);
      step("rd1_99", 1'b0, 8'h00, 1'b1, 2'b00, 1'b0);

      // Store into full with same-cycle read is still dropped
      for (int i = 0; i < 64; i++) step("refill", 1'b1, 8'(8'hC0 + i), 1'b0, 2'b00, 1'b0);
      step("full_st_rd", 1'b1, 8'hAA, 1'b1, 2'b00, 1'b0);
      chk("full_st_rd_occ", {25'h0, buffer_occupancy}, 32'd63);

      // Clear with flags set, store/get ignored
      step("clear", 1'b1, 8'h55, 1'b1, 2'b00, 1'b1);
      chk("clear_rx_out", rx_out, 32'h0);
      chk("clear_ovf", {31'h0, overflow}, 32'h0);
      step("post_clear_rd", 1'b0, 8'h00, 1'b1, 2'b00, 1'b0);

      // Asynchronous reset mid-operation
      step("pre_rst_st", 1'b1, 8'h12, 1'b0, 2'b00, 1'b0);
      step("pre_rst_st2", 1'b1, 8'h34, 1'b0, 2'b00, 1'b0);
      @(negedge clk);
      #2 n_rst = 1'b0;
      #1;
      chk("async_rst_occ", {25'h0, buffer_occupancy}, 32'd0);
      chk("async_rst_empty", {31'h0, empty}, 32'h1);
      chk("async_rst_unf", {31'h0, underflow}, 32'h0);
      model_reset();
      @(negedge clk);
      n_rst = 1'b1;
      step("post_rst", 1'b0, 8'h00, 1'b0, 2'b00, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
